// File: rtl/dmem_req_pkg.sv
// Shared definitions for the data-memory requester: FSM state encoding and
// default sizes for the dmem port.
package dmem_req_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 9;
    localparam int MEM_WORDS_DEF = 512;

    // One access walks IDLE -> READ|WRITE -> RESP -> IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_addr_map.sv
// Byte address to dmem word index translation.
// Optional feature macro: DMEM_RANGE_CHECK_EN
//   defined   : addr_err flags indices >= MEM_WORDS or nonzero upper address bits
//   undefined : addr_err is 0 and upper address bits wrap modulo 2^ADDR_W words
module dmem_addr_map #(
    parameter int ADDR_W    = 9,
    parameter int MEM_WORDS = 512
) (
    input  logic [31:0]       byte_addr,
    output logic [ADDR_W-1:0] word_index,
    output logic              addr_err
);

    // Word accesses only: the two byte-offset bits never select anything
    assign word_index = byte_addr[ADDR_W+1:2];

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic [32:0] MEM_WORDS_W = 33'(MEM_WORDS);

    logic unused_offset;
    assign unused_offset = ^byte_addr[1:0];

    assign addr_err = (byte_addr[31:ADDR_W+2] != '0) ||
                      (33'(word_index) >= MEM_WORDS_W);
`else
    localparam int unused_mem_words = MEM_WORDS;

    logic unused_bits;
    assign unused_bits = ^{byte_addr[31:ADDR_W+2], byte_addr[1:0]};

    assign addr_err = 1'b0;
`endif

endmodule

// File: rtl/dmem_requester.sv
// Initiator side of the data-memory port. Takes one load/store at a time from
// the MEM stage, performs a single-cycle level-sensitive dmem access and hands
// the result back on a valid/ready response channel.
// Optional feature macro: DMEM_RANGE_CHECK_EN (address range checking; errored
// requests skip the dmem access and answer one cycle earlier).
module dmem_requester
    import dmem_req_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [31:0]       reqAddr,
    input  logic [DATA_W-1:0] reqData,
    output logic              respValid,
    input  logic              respReady,
    output logic [DATA_W-1:0] respData,
    output logic              respErr,
    output logic [ADDR_W-1:0] memReadAddress,
    output logic [ADDR_W-1:0] memWriteAddress,
    output logic [DATA_W-1:0] memWriteData,
    output logic              memReadWrite,
    input  logic [DATA_W-1:0] memReadData
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] word_index;
    logic              addr_err;
    logic              accept;

    dmem_addr_map #(
        .ADDR_W    (ADDR_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_addr_map (
        .byte_addr  (reqAddr),
        .word_index (word_index),
        .addr_err   (addr_err)
    );

    assign accept = (state == IDLE) && reqValid;

    // State register; reset returns to IDLE at once, abandoning any access
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: one access cycle, then wait in RESP until the CPU takes it
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (reqValid) begin
                    if (addr_err) begin
                        state_next = RESP;
                    end else if (reqWrite) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:    state_next = RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = respReady ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and write strobe are pure functions of state so reset kills them immediately
    always_comb begin
        reqReady     = (state == IDLE);
        respValid    = (state == RESP);
        memReadWrite = (state == WRITE);
    end

    // Mem address/data are captured at accept so they are stable before and during the strobe
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            memReadAddress  <= '0;
            memWriteAddress <= '0;
            memWriteData    <= '0;
        end else if (accept && !addr_err) begin
            if (reqWrite) begin
                memWriteAddress <= word_index;
                memWriteData    <= reqData;
            end else begin
                memReadAddress  <= word_index;
            end
        end
    end

    // Response data: dmem read word for loads, zero for stores and errored requests
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            respData <= '0;
        end else begin
            case (state)
                READ:    respData <= memReadData;
                WRITE:   respData <= '0;
                IDLE:    if (accept && addr_err) respData <= '0;
                default: respData <= respData;
            endcase
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic resp_err;

    // Error flag is decided at accept and held through RESP
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            resp_err <= 1'b0;
        end else if (accept) begin
            resp_err <= addr_err;
        end
    end

    assign respErr = resp_err;
`else
    assign respErr = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_requester.sv
// Self-checking bench for dmem_requester with a behavioural dmem stub and a
// word-array reference model. Build with DMEM_RANGE_CHECK_EN to exercise the
// range-check configuration (MEM_WORDS=256).
module tb_dmem_requester;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
`ifdef DMEM_RANGE_CHECK_EN
    localparam int MEM_WORDS_TB = 256;
`else
    localparam int MEM_WORDS_TB = 512;
`endif

    logic              clk;
    logic              resetN;
    logic              reqValid;
    logic              reqReady;
    logic              reqWrite;
    logic [31:0]       reqAddr;
    logic [DATA_W-1:0] reqData;
    logic              respValid;
    logic              respReady;
    logic [DATA_W-1:0] respData;
    logic              respErr;
    logic [ADDR_W-1:0] memReadAddress;
    logic [ADDR_W-1:0] memWriteAddress;
    logic [DATA_W-1:0] memWriteData;
    logic              memReadWrite;
    logic [DATA_W-1:0] memReadData;

    int errors = 0;
    int checks = 0;

    dmem_requester #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_WORDS (MEM_WORDS_TB)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .reqValid        (reqValid),
        .reqReady        (reqReady),
        .reqWrite        (reqWrite),
        .reqAddr         (reqAddr),
        .reqData         (reqData),
        .respValid       (respValid),
        .respReady       (respReady),
        .respData        (respData),
        .respErr         (respErr),
        .memReadAddress  (memReadAddress),
        .memWriteAddress (memWriteAddress),
        .memWriteData    (memWriteData),
        .memReadWrite    (memReadWrite),
        .memReadData     (memReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmem stub: combinational read, write while readWrite is high at the clock edge
    logic [DATA_W-1:0] mem [0:511];
    logic              init_mem;
    assign memReadData = mem[memReadAddress];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 512; i++) mem[i] <= initWord(i);
        end else if (memReadWrite) begin
            mem[memWriteAddress] <= memWriteData;
        end
    end

    // Reference model: what each word of memory should hold
    logic [31:0] ref_mem [0:511];

    function automatic logic [31:0] initWord(input int i);
        return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
    endfunction

    function automatic int wordOf(input logic [31:0] addr);
        return int'((addr >> 2) % 512);
    endfunction

    function automatic logic isErr(input logic [31:0] addr);
`ifdef DMEM_RANGE_CHECK_EN
        return (addr >> 2) >= 32'(MEM_WORDS_TB);
`else
        return (addr == 32'hFFFF_FFFF) && (addr != 32'hFFFF_FFFF);
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One complete transaction from IDLE with respReady held low until the response appears
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                 output logic [31:0] rdata, output logic rerr, output int lat,
                                 output int pulses, output logic [8:0] seen_addr);
        pulses    = 0;
        seen_addr = '0;
        reqWrite  = wr;
        reqAddr   = addr;
        reqData   = data;
        reqValid  = 1'b1;
        respReady = 1'b0;
        checkOutput("reqReady_idle", 64'(reqReady), 64'd1);
        @(posedge clk); #1;
        reqValid = 1'b0;
        lat = 1;
        while (!respValid && lat < 10) begin
            if (memReadWrite) begin
                pulses++;
                seen_addr = memWriteAddress;
            end else if (!wr) begin
                seen_addr = memReadAddress;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!respValid) checkOutput("resp_timeout", 64'(respValid), 64'd1);
        rdata = respData;
        rerr  = respErr;
        respReady = 1'b1;
        @(posedge clk); #1;
        respReady = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic [8:0]  exp_word;
    } vec_t;

    vec_t        vecs [0:6];
    logic [31:0] rd;
    logic        re;
    int          lat;
    int          pul;
    logic [8:0]  sa;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [31:0] exp_q [$];
    logic        b_wr  [0:15];
    logic [31:0] b_adr [0:15];
    logic [31:0] b_dat [0:15];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 9'd4};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 9'd4};
        vecs[2] = '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 9'd4};
        vecs[3] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0, 9'd255};
        vecs[4] = '{1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 9'd255};
        vecs[5] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0, 9'd0};
        vecs[6] = '{1'b0, 32'h0000_0001, 32'h0,         32'h0, 9'd0};

        for (int i = 0; i < 512; i++) ref_mem[i] = initWord(i);
        init_mem  = 1'b1;
        resetN    = 1'b0;
        reqValid  = 1'b0;
        reqWrite  = 1'b0;
        reqAddr   = '0;
        reqData   = '0;
        respReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        init_mem = 1'b0;
        checkOutput("rst_respValid", 64'(respValid), 64'd0);
        checkOutput("rst_respData", 64'(respData), 64'd0);
        checkOutput("rst_memReadWrite", 64'(memReadWrite), 64'd0);
        checkOutput("rst_memAddr", 64'({memReadAddress, memWriteAddress}), 64'd0);
        checkOutput("rst_memWriteData", 64'(memWriteData), 64'd0);
        @(negedge clk) resetN = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_reqReady", 64'(reqReady), 64'd1);
        checkOutput("rst_respErr", 64'(respErr), 64'd0);

        $display("[TB] table vectors");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, re, lat, pul, sa);
            checkOutput($sformatf("vec%0d_data", i), 64'(rd), 64'(vecs[i].exp_data));
            checkOutput($sformatf("vec%0d_err", i), 64'(re), 64'd0);
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
            checkOutput($sformatf("vec%0d_pulses", i), 64'(pul), vecs[i].wr ? 64'd1 : 64'd0);
            checkOutput($sformatf("vec%0d_word", i), 64'(sa), 64'(vecs[i].exp_word));
            if (vecs[i].wr) ref_mem[vecs[i].exp_word] = vecs[i].data;
        end

        $display("[TB] reset during write");
        reqWrite = 1'b1;
        reqAddr  = 32'h0000_0050;
        reqData  = 32'hBAD0_BAD0;
        reqValid = 1'b1;
        @(posedge clk); #1;
        reqValid = 1'b0;
        checkOutput("midwr_strobe_before", 64'(memReadWrite), 64'd1);
        #2 resetN = 1'b0;
        #1;
        checkOutput("midwr_strobe_dropped", 64'(memReadWrite), 64'd0);
        @(negedge clk) resetN = 1'b1;
        @(posedge clk); #1;
        checkOutput("midwr_reqReady", 64'(reqReady), 64'd1);
        checkOutput("midwr_respValid", 64'(respValid), 64'd0);
        checkOutput("midwr_memWriteAddress", 64'(memWriteAddress), 64'd0);
        respReady = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checkOutput("midwr_no_response", 64'(respValid), 64'd0);
            @(posedge clk); #1;
        end
        respReady = 1'b0;
        applyStimulus(1'b0, 32'h0000_0050, 32'h0, rd, re, lat, pul, sa);
        checkOutput("midwr_word_untouched", 64'(rd), 64'(ref_mem[20]));

        $display("[TB] backpressure");
        exp1 = ref_mem[4];
        exp2 = ref_mem[7];
        reqWrite  = 1'b0;
        reqAddr   = 32'h0000_0010;
        reqValid  = 1'b1;
        respReady = 1'b0;
        @(posedge clk); #1;
        reqAddr = 32'h0000_001C;
        for (int k = 0; k < 10 && !respValid; k++) begin
            @(posedge clk); #1;
        end
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_respValid", 64'(respValid), 64'd1);
            checkOutput("bp_respData", 64'(respData), 64'(exp1));
            checkOutput("bp_reqReady", 64'(reqReady), 64'd0);
            @(posedge clk); #1;
        end
        respReady = 1'b1;
        @(posedge clk); #1;
        respReady = 1'b0;
        checkOutput("bp_released_valid", 64'(respValid), 64'd0);
        checkOutput("bp_released_ready", 64'(reqReady), 64'd1);
        @(posedge clk); #1;
        reqValid = 1'b0;
        checkOutput("bp_second_accepted", 64'(reqReady), 64'd0);
        for (int k = 0; k < 10 && !respValid; k++) begin
            @(posedge clk); #1;
        end
        checkOutput("bp_second_data", 64'(respData), 64'(exp2));
        respReady = 1'b1;
        @(posedge clk); #1;
        respReady = 1'b0;

`ifdef DMEM_RANGE_CHECK_EN
        $display("[TB] range check");
        applyStimulus(1'b0, 32'h0000_0400, 32'h0, rd, re, lat, pul, sa);
        checkOutput("rc_load_err", 64'(re), 64'd1);
        checkOutput("rc_load_data", 64'(rd), 64'd0);
        checkOutput("rc_load_latency", 64'(lat), 64'd1);
        checkOutput("rc_load_pulses", 64'(pul), 64'd0);
        applyStimulus(1'b1, 32'h0000_03FC, 32'h1357_9BDF, rd, re, lat, pul, sa);
        ref_mem[255] = 32'h1357_9BDF;
        checkOutput("rc_store_err", 64'(re), 64'd0);
        checkOutput("rc_store_pulses", 64'(pul), 64'd1);
        applyStimulus(1'b1, 32'h1000_0000, 32'hFFFF_FFFF, rd, re, lat, pul, sa);
        checkOutput("rc_highbits_err", 64'(re), 64'd1);
        checkOutput("rc_highbits_pulses", 64'(pul), 64'd0);
`else
        $display("[TB] address wrap");
        applyStimulus(1'b0, 32'h0000_0804, 32'h0, rd, re, lat, pul, sa);
        checkOutput("wrap_word", 64'(sa), 64'd1);
        checkOutput("wrap_data", 64'(rd), 64'(ref_mem[1]));
        applyStimulus(1'b0, 32'hFFFF_F813, 32'h0, rd, re, lat, pul, sa);
        checkOutput("wrap_high_word", 64'(sa), 64'(wordOf(32'hFFFF_F813)));
        checkOutput("wrap_high_err", 64'(re), 64'd0);
`endif

        $display("[TB] random transactions");
        for (int t = 0; t < 40; t++) begin
            logic        wr;
            logic [31:0] addr;
            logic [31:0] data;
            logic        err;
            int          w;
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            data = $urandom;
            err  = isErr(addr);
            w    = wordOf(addr);
            applyStimulus(wr, addr, data, rd, re, lat, pul, sa);
            checkOutput($sformatf("rnd%0d_err", t), 64'(re), 64'(err));
            checkOutput($sformatf("rnd%0d_latency", t), 64'(lat), err ? 64'd1 : 64'd2);
            checkOutput($sformatf("rnd%0d_pulses", t), 64'(pul), (wr && !err) ? 64'd1 : 64'd0);
            if (err || wr) begin
                checkOutput($sformatf("rnd%0d_data", t), 64'(rd), 64'd0);
            end else begin
                checkOutput($sformatf("rnd%0d_data", t), 64'(rd), 64'(ref_mem[w]));
            end
            if (!err) checkOutput($sformatf("rnd%0d_word", t), 64'(sa), 64'(w));
            if (wr && !err) ref_mem[w] = data;
        end

        $display("[TB] back-to-back");
        for (int i = 0; i < 8; i++) begin
            b_wr[2*i]    = 1'b1;
            b_adr[2*i]   = 32'(i * 4);
            b_dat[2*i]   = $urandom;
            b_wr[2*i+1]  = 1'b0;
            b_adr[2*i+1] = 32'(i * 4);
            b_dat[2*i+1] = 32'h0;
        end
        begin
            int idx;
            int cycle;
            int resp_count;
            int last_resp;
            logic acc;
            idx = 0;
            cycle = 0;
            resp_count = 0;
            last_resp = 0;
            respReady = 1'b1;
            reqWrite = b_wr[0];
            reqAddr  = b_adr[0];
            reqData  = b_dat[0];
            reqValid = 1'b1;
            while (cycle < 200 && resp_count < 16) begin
                acc = reqValid && reqReady;
                if (acc) begin
                    if (b_wr[idx]) begin
                        ref_mem[wordOf(b_adr[idx])] = b_dat[idx];
                        exp_q.push_back(32'h0);
                    end else begin
                        exp_q.push_back(ref_mem[wordOf(b_adr[idx])]);
                    end
                end
                if (respValid) begin
                    if (exp_q.size() > 0) begin
                        checkOutput($sformatf("b2b%0d_data", resp_count), 64'(respData), 64'(exp_q.pop_front()));
                    end else begin
                        checkOutput("b2b_unexpected_resp", 64'(respValid), 64'd0);
                    end
                    if (resp_count > 0) checkOutput($sformatf("b2b%0d_spacing", resp_count), 64'(cycle - last_resp), 64'd3);
                    last_resp = cycle;
                    resp_count++;
                end
                @(posedge clk); #1;
                cycle++;
                if (acc) begin
                    idx++;
                    if (idx < 16) begin
                        reqWrite = b_wr[idx];
                        reqAddr  = b_adr[idx];
                        reqData  = b_dat[idx];
                    end else begin
                        reqValid = 1'b0;
                    end
                end
            end
            checkOutput("b2b_response_count", 64'(resp_count), 64'd16);
            reqValid  = 1'b0;
            respReady = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
